adder_subtracter: RTL and testbench
===================================

// Module: adder_subtracter
// PURPOSE
//   Registered N-bit two's-complement adder/subtractor with carry-in and carry-out.
//   SUB selects the operation:
//     SUB=0: A + B + C_in
//     SUB=1: A - B - C_in
//   Datapath leaf block for ALU-style arithmetic. Result and carry are registered once.
// PARAMETERS
//   width  8  operand and result width in bits (legal: >=1)
// PORTS
//   clk    in   1      single clock; all state updates on rising edge
//   rst_n  in   1      synchronous reset, active-low; sampled on rising clk
//   A      in   width  operand A (unsigned / two's complement)
//   B      in   width  operand B
//   C_in   in   1      carry-in (SUB=0) / borrow-in (SUB=1)
//   SUB    in   1      0 = add, 1 = subtract
//   OUT    out  width  registered result, modulo 2^width
//   Carry  out  1      registered carry-out of the width-bit adder
// BEHAVIOUR
//   - One clock; reset is synchronous and active-low (clk, rst_n).
//   - Reset: rst_n=0 at a rising edge -> OUT=0, Carry=0. Reset wins over any input.
//   - Latency 1 cycle: inputs sampled at edge k appear on OUT/Carry after edge k. No handshake;
//     a new operation is accepted every cycle.
//   - Add (SUB=0): {Carry,OUT} = A + B + C_in, computed at width+1 bits.
//   - Subtract (SUB=1): {Carry,OUT} = A + ~B + ~C_in, computed at width+1 bits.
//     - Gives OUT = A - B - C_in mod 2^width.
//     - Carry=1 means no borrow (A >= B + C_in, unsigned); Carry=0 means a borrow occurred.
//   - Boundaries:
//     - Add wrap: 0xFF + 0x01 -> OUT=0x00, Carry=1.
//     - Sub underflow: 0x00 - 0x01 -> OUT=0xFF, Carry=0.
//     - A == B with C_in=0, SUB=1 -> OUT=0, Carry=1.
//   - X/Z on inputs is not required to be handled; outputs only need to be defined after reset.
//   - Reset asserted mid-stream clears the pipeline register. The first valid result follows the
//     first sampled edge with rst_n=1.
// CONFIGURATION
//   - Macro ADDSUB_FLAGS_EN. When defined, two extra registered outputs exist:
//     - Overflow  out 1: signed overflow, (A[msb]==B'[msb]) && (OUT[msb]!=A[msb]),
//       where B' is the effective (inverted for SUB) operand.
//     - Zero      out 1: OUT == 0.
//     - Both reset to 0 and have the same 1-cycle latency as OUT.
//   - When undefined, these ports and their logic are absent; all other behaviour is identical.
// STRUCTURE
//   - No shared package required. A local constant for width+1 may live in the module.
//   - Sub-module full_adder (a, b, cin -> sum, cout) is instantiated width times in a
//     generate ripple chain:
//     - chain carry-in = C_in ^ SUB;
//     - B inverted per bit by SUB (XOR).
//   - The top level holds the XOR conditioning, the chain, the output register and the
//     optional flag logic.
// TESTING
//   - Reset: rst_n=0 for 2 edges with arbitrary inputs -> OUT=0x00, Carry=0. Release -> follows
//     inputs after 1 edge.
//   - A=0x00, B=0x01, C_in=0, SUB=0 -> OUT=0x01, Carry=0.
//   - A=0xA0, B=0x0A, C_in=0, SUB=0 -> OUT=0xAA, Carry=0. Same operands with C_in=1 -> OUT=0xAB.
//   - Subtract, C_in=0, SUB=1:
//     - A=0x0A, B=0x0A -> OUT=0x00, Carry=1.
//     - A=0xFF, B=0xAA -> OUT=0x55, Carry=1.
//   - Wrap and borrow:
//     - A=0xFF, B=0x01, SUB=0 -> OUT=0x00, Carry=1.
//     - A=0x00, B=0x01, SUB=1 -> OUT=0xFF, Carry=0.
//     - A=0x05, B=0x03, C_in=1, SUB=1 -> OUT=0x01, Carry=1.
//   - ADDSUB_FLAGS_EN:
//     - A=0x7F, B=0x01, SUB=0 -> OUT=0x80, Overflow=1, Zero=0.
//     - A=0x0A, B=0x0A, SUB=1 -> Zero=1, Overflow=0.
//     - Random back-to-back ops each cycle checked against a reference model at latency 1.

Source files
------------

// File: rtl/adder_subtracter_pkg.sv
// Shared constants and types for the adder_subtracter datapath block.
// Optional build macro: ADDSUB_FLAGS_EN (adds registered Overflow/Zero flags to the top).
package adder_subtracter_pkg;

    // Operand width used when the top is instantiated without overrides
    localparam int DEFAULT_WIDTH = 8;

    // Encoding of the SUB select input
    typedef enum logic {
        OP_ADD = 1'b0,
        OP_SUB = 1'b1
    } op_e;

    // Carry injected at bit 0: subtract turns the borrow-in into ~C_in
    function automatic logic chain_carry_in(input logic c_in, input logic sub);
        return c_in ^ sub;
    endfunction

endpackage

// File: rtl/adder_subtracter_full_adder.sv
// Single-bit full adder cell used as one stage of the ripple-carry chain.
module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);

    // Purely combinational sum and carry of three input bits
    always_comb begin
        sum  = a ^ b ^ cin;
        cout = (a & b) | (a & cin) | (b & cin);
    end

endmodule

// File: rtl/adder_subtracter.sv
// Registered N-bit two's-complement adder/subtractor with carry-in and carry-out.
// SUB=0 computes A + B + C_in, SUB=1 computes A + ~B + ~C_in (= A - B - C_in).
// Carry is the raw carry-out of the adder, so on subtract Carry=1 means "no borrow".
// Optional build macro: ADDSUB_FLAGS_EN adds registered Overflow and Zero outputs.
module adder_subtracter
    import adder_subtracter_pkg::*;
#(
    parameter int width = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [width-1:0] A,
    input  logic [width-1:0] B,
    input  logic             C_in,
    input  logic             SUB,
    output logic [width-1:0] OUT,
    output logic             Carry
`ifdef ADDSUB_FLAGS_EN
    ,
    output logic             Overflow,
    output logic             Zero
`endif
);

    localparam int sum_width = width + 1;

    logic                 invert_b;
    logic [width-1:0]     b_eff;
    logic [width:0]       carry_chain;
    logic [width-1:0]     sum_bits;
    logic [sum_width-1:0] result;

    // Condition operand B and the chain carry-in according to the selected operation
    always_comb begin
        invert_b       = (SUB == OP_SUB);
        b_eff          = B ^ {width{invert_b}};
        carry_chain[0] = chain_carry_in(C_in, SUB);
    end

    // Ripple chain: one full adder per bit, carry flowing from LSB to MSB
    for (genvar i = 0; i < width; i++) begin : g_ripple
        full_adder u_fa (
            .a    (A[i]),
            .b    (b_eff[i]),
            .cin  (carry_chain[i]),
            .sum  (sum_bits[i]),
            .cout (carry_chain[i+1])
        );
    end

    assign result = {carry_chain[width], sum_bits};

`ifdef ADDSUB_FLAGS_EN
    logic overflow_next;
    logic zero_next;

    // Signed overflow: operands agree in sign but the result sign differs
    always_comb begin
        overflow_next = (A[width-1] == b_eff[width-1]) && (sum_bits[width-1] != A[width-1]);
        zero_next     = (sum_bits == '0);
    end

    // Flag register shares the result's single-cycle latency and synchronous clear
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            Overflow <= 1'b0;
            Zero     <= 1'b0;
        end else begin
            Overflow <= overflow_next;
            Zero     <= zero_next;
        end
    end
`endif

    // Output register: reset wins, otherwise capture a new result every cycle
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            OUT   <= '0;
            Carry <= 1'b0;
        end else begin
            OUT   <= result[width-1:0];
            Carry <= result[sum_width-1];
        end
    end

endmodule

// File: tb/tb_adder_subtracter.sv
// Self-checking bench for adder_subtracter (width 8): directed vector table,
// reset sequences, and back-to-back random operations against an integer model.
// Flag checks are active when ADDSUB_FLAGS_EN is defined.
module tb_adder_subtracter;

    logic       clk;
    logic       rst_n;
    logic [7:0] a_in;
    logic [7:0] b_in;
    logic       c_in;
    logic       sub_in;
    logic [7:0] out_q;
    logic       carry_q;
`ifdef ADDSUB_FLAGS_EN
    logic       overflow_q;
    logic       zero_q;
`endif

    int check_count = 0;
    int error_count = 0;

    typedef struct {
        string      name;
        logic [7:0] a;
        logic [7:0] b;
        logic       cin;
        logic       sub;
        logic [7:0] exp_out;
        logic       exp_carry;
        logic       exp_ovf;
        logic       exp_zero;
    } vec_t;

    vec_t vecs[12];

    adder_subtracter #(.width(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .A     (a_in),
        .B     (b_in),
        .C_in  (c_in),
        .SUB   (sub_in),
        .OUT   (out_q),
        .Carry (carry_q)
`ifdef ADDSUB_FLAGS_EN
        ,
        .Overflow (overflow_q),
        .Zero     (zero_q)
`endif
    );

    // 10 time-unit clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive one set of inputs on the falling edge, away from the capture edge
    task automatic applyStimulus(input logic rst, input logic [7:0] a, input logic [7:0] b,
                                 input logic cin, input logic sub);
        @(negedge clk);
        rst_n  = rst;
        a_in   = a;
        b_in   = b;
        c_in   = cin;
        sub_in = sub;
    endtask

    // Compare registered outputs against expected values
    task automatic checkOutput(input string name, input logic [7:0] exp_out, input logic exp_carry,
                               input logic exp_ovf, input logic exp_zero);
        check_count++;
        if (out_q !== exp_out) begin
            error_count++;
            $display("[TB] FAIL %s OUT: got 0x%02h expected 0x%02h", name, out_q, exp_out);
        end
        check_count++;
        if (carry_q !== exp_carry) begin
            error_count++;
            $display("[TB] FAIL %s Carry: got %b expected %b", name, carry_q, exp_carry);
        end
`ifdef ADDSUB_FLAGS_EN
        check_count++;
        if (overflow_q !== exp_ovf) begin
            error_count++;
            $display("[TB] FAIL %s Overflow: got %b expected %b", name, overflow_q, exp_ovf);
        end
        check_count++;
        if (zero_q !== exp_zero) begin
            error_count++;
            $display("[TB] FAIL %s Zero: got %b expected %b", name, zero_q, exp_zero);
        end
`else
        if (exp_ovf === 1'bx || exp_zero === 1'bx) begin
            $display("[TB] note: %s has undefined flag expectations", name);
        end
`endif
    endtask

    // Integer reference model, independent of the chain structure
    task automatic modelOp(input logic [7:0] a, input logic [7:0] b, input logic cin, input logic sub,
                           output logic [7:0] exp_out, output logic exp_carry,
                           output logic exp_ovf, output logic exp_zero);
        int ua, ub, sa, sb, ures, sres;
        ua = int'(a);
        ub = int'(b);
        sa = (ua >= 128) ? ua - 256 : ua;
        sb = (ub >= 128) ? ub - 256 : ub;
        if (!sub) begin
            ures      = ua + ub + int'(cin);
            sres      = sa + sb + int'(cin);
            exp_carry = (ures >= 256);
        end else begin
            ures      = ua - ub - int'(cin);
            sres      = sa - sb - int'(cin);
            exp_carry = (ua >= ub + int'(cin));
        end
        exp_out  = 8'(ures & 255);
        exp_ovf  = (sres > 127) || (sres < -128);
        exp_zero = ((ures & 255) == 0);
    endtask

    initial begin
        logic [7:0] exp_out, ra, rb;
        logic       exp_carry, exp_ovf, exp_zero, rc, rs;

        //            name          a      b      cin   sub   out    cy    ovf   zero
        vecs[0]  = '{"add_0_1",     8'h00, 8'h01, 1'b0, 1'b0, 8'h01, 1'b0, 1'b0, 1'b0};
        vecs[1]  = '{"add_a0_0a",   8'hA0, 8'h0A, 1'b0, 1'b0, 8'hAA, 1'b0, 1'b0, 1'b0};
        vecs[2]  = '{"add_a0_0a_c", 8'hA0, 8'h0A, 1'b1, 1'b0, 8'hAB, 1'b0, 1'b0, 1'b0};
        vecs[3]  = '{"sub_equal",   8'h0A, 8'h0A, 1'b0, 1'b1, 8'h00, 1'b1, 1'b0, 1'b1};
        vecs[4]  = '{"sub_ff_aa",   8'hFF, 8'hAA, 1'b0, 1'b1, 8'h55, 1'b1, 1'b0, 1'b0};
        vecs[5]  = '{"add_wrap",    8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1};
        vecs[6]  = '{"sub_borrow",  8'h00, 8'h01, 1'b0, 1'b1, 8'hFF, 1'b0, 1'b0, 1'b0};
        vecs[7]  = '{"sub_bin",     8'h05, 8'h03, 1'b1, 1'b1, 8'h01, 1'b1, 1'b0, 1'b0};
        vecs[8]  = '{"add_max_c",   8'hFF, 8'hFF, 1'b1, 1'b0, 8'hFF, 1'b1, 1'b0, 1'b0};
        vecs[9]  = '{"sub_ovf",     8'h80, 8'h7F, 1'b0, 1'b1, 8'h01, 1'b1, 1'b1, 1'b0};
        vecs[10] = '{"sub_0_0_bin", 8'h00, 8'h00, 1'b1, 1'b1, 8'hFF, 1'b0, 1'b0, 1'b0};
        vecs[11] = '{"add_ovf",     8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1, 1'b0};

        // Reset held for two edges with inputs that would otherwise give a nonzero result
        rst_n = 1'b0; a_in = 8'hFF; b_in = 8'hFF; c_in = 1'b1; sub_in = 1'b0;
        applyStimulus(1'b0, 8'hFF, 8'hFF, 1'b1, 1'b0);
        applyStimulus(1'b0, 8'hC3, 8'h5A, 1'b1, 1'b0);
        @(negedge clk);
        checkOutput("reset", 8'h00, 1'b0, 1'b0, 1'b0);

        // Release: result follows inputs after one edge
        applyStimulus(1'b1, 8'h12, 8'h34, 1'b0, 1'b0);
        @(negedge clk);
        checkOutput("release", 8'h46, 1'b0, 1'b0, 1'b0);

        // Directed vector table
        for (int i = 0; i < 12; i++) begin
            applyStimulus(1'b1, vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].sub);
            @(negedge clk);
            checkOutput(vecs[i].name, vecs[i].exp_out, vecs[i].exp_carry,
                        vecs[i].exp_ovf, vecs[i].exp_zero);
        end

        // Mid-stream reset clears a result that had Carry set
        applyStimulus(1'b1, 8'hFF, 8'h01, 1'b0, 1'b0);
        @(negedge clk);
        checkOutput("pre_mid_reset", 8'h00, 1'b1, 1'b0, 1'b1);
        rst_n = 1'b0; a_in = 8'hFF; b_in = 8'hFF; c_in = 1'b1; sub_in = 1'b0;
        @(negedge clk);
        checkOutput("mid_reset", 8'h00, 1'b0, 1'b0, 1'b0);
        rst_n = 1'b1; a_in = 8'h10; b_in = 8'h01; c_in = 1'b0; sub_in = 1'b0;
        @(negedge clk);
        checkOutput("post_mid_reset", 8'h11, 1'b0, 1'b0, 1'b0);

        // Back-to-back random operations, a new op every cycle, checked at latency 1
        ra = 8'($urandom_range(0, 255));
        rb = 8'($urandom_range(0, 255));
        rc = 1'($urandom_range(0, 1));
        rs = 1'($urandom_range(0, 1));
        a_in = ra; b_in = rb; c_in = rc; sub_in = rs;
        for (int i = 0; i < 200; i++) begin
            modelOp(ra, rb, rc, rs, exp_out, exp_carry, exp_ovf, exp_zero);
            @(negedge clk);
            checkOutput($sformatf("rand_%0d", i), exp_out, exp_carry, exp_ovf, exp_zero);
            ra = 8'($urandom_range(0, 255));
            rb = 8'($urandom_range(0, 255));
            rc = 1'($urandom_range(0, 1));
            rs = 1'($urandom_range(0, 1));
            a_in = ra; b_in = rb; c_in = rc; sub_in = rs;
        end

        $display("Simulation finished: %0d checks, %0d errors", check_count, error_count);
        $finish;
    end

endmodule
